// File: rtl/sh_mem_arbiter.sv
// sh_mem_arbiter: shares one single-ported, variable-latency memory between
// the CPU fetch path and the CPU data path. Data has fixed priority; a
// saturating starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data grants won against a waiting fetch.
module sh_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    stall,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    dt_req,
    input  logic [ADDR_WIDTH-1:0]   dt_addr,
    input  logic                    dt_we,
    input  logic [DATA_WIDTH/8-1:0] dt_be,
    input  logic [DATA_WIDTH-1:0]   dt_wdata,
    output logic                    dt_ack,
    output logic [DATA_WIDTH-1:0]   dt_rdata,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    grant,
    output logic                    busy
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 pick_data;
    logic                 fetch_starved;

    // Winner selection: data first unless a waiting fetch has been starved long enough
    always_comb begin
        fetch_starved = 1'b0;
        pick_data     = 1'b0;
        fetch_starved = (starve_cnt >= LIMIT);
        pick_data     = dt_req && !(if_req && fetch_starved);
    end

    // Arbitration FSM with registered memory payload, acks and read data
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dt_ack     <= 1'b0;
            if_rdata   <= '0;
            dt_rdata   <= '0;
            grant      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dt_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stall && (if_req || dt_req)) begin
                        state   <= BUSY;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        grant   <= pick_data;
                        if (pick_data) begin
                            mem_addr  <= dt_addr;
                            mem_we    <= dt_we;
                            mem_be    <= dt_be;
                            mem_wdata <= dt_wdata;
                            // A data win implies the counter is below the limit when fetch waits
                            if (if_req && !fetch_starved) begin
                                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            mem_addr   <= if_addr;
                            mem_we     <= 1'b0;
                            mem_be     <= {BE_WIDTH{1'b1}};
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (grant) begin
                            dt_ack <= 1'b1;
                            if (!mem_we) begin
                                dt_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sh_mem_arbiter.sv
// Self-checking bench for sh_mem_arbiter: a wait-state memory responder, a
// starvation-counter model feeding a scoreboard queue, and one task per scenario.
module tb_sh_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned LIMIT = 3;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          stall;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dt_req;
    logic [AW-1:0] dt_addr;
    logic          dt_we;
    logic [BW-1:0] dt_be;
    logic [DW-1:0] dt_wdata;
    logic          dt_ack;
    logic [DW-1:0] dt_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          grant;
    logic          busy;

    sh_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .stall    (stall),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dt_req   (dt_req),
        .dt_addr  (dt_addr),
        .dt_we    (dt_we),
        .dt_be    (dt_be),
        .dt_wdata (dt_wdata),
        .dt_ack   (dt_ack),
        .dt_rdata (dt_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_data;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_cnt = 0;
    logic [DW-1:0] exp_dt_rdata = '0;

    // Memory responder state, observed on the falling edge
    int            ws = 0;
    int            cyc = 0;
    int            n_hs = 0;
    int            last_cycles = 0;
    logic          seen = 1'b0;
    logic          unstable = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          last_we = 1'b0;
    logic [BW-1:0] last_be = '0;
    logic [DW-1:0] last_wdata = '0;

    function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
        return 32'hE0010009 ^ a ^ 32'h0000_0100;
    endfunction

    // Reference model of the grant decision and starvation counter
    function automatic void push_exp(input logic is_data, input logic fetch_wait,
                                     input logic [AW-1:0] a, input logic we,
                                     input logic [BW-1:0] be, input logic [DW-1:0] wd,
                                     input logic [DW-1:0] rd);
        exp_t e;
        if (is_data) begin
            if (fetch_wait && m_cnt < int'(LIMIT)) m_cnt = m_cnt + 1;
        end else begin
            m_cnt = 0;
        end
        e.is_data = is_data; e.addr = a; e.we = we; e.be = be;
        e.wdata = wd; e.rdata = rd; e.cnt = m_cnt;
        sb.push_back(e);
    endfunction

    // Memory with ws wait states; records the payload of each request
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (!seen) begin
                seen = 1'b1; cyc = 0; unstable = 1'b0;
                last_addr = mem_addr; last_we = mem_we; last_be = mem_be; last_wdata = mem_wdata;
            end else if (mem_addr !== last_addr || mem_we !== last_we ||
                         mem_be !== last_be || mem_wdata !== last_wdata) begin
                unstable = 1'b1;
            end
            cyc = cyc + 1;
            last_cycles = cyc;
            if (cyc > ws) begin
                mem_ready = 1'b1; mem_rdata = mval(mem_addr); n_hs = n_hs + 1;
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0; seen = 1'b0;
        end
    end

    task automatic wait_ack(input int budget, output int lat, output logic gi, output logic gd);
        lat = 0; gi = 1'b0; gd = 1'b0;
        while (lat < budget && !gi && !gd) begin
            @(negedge clk);
            lat = lat + 1;
            gi = if_ack; gd = dt_ack;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; stall = 1'b0; if_req = 1'b0; if_addr = '0; dt_req = 1'b0;
        dt_addr = '0; dt_we = 1'b0; dt_be = '0; dt_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0; m_cnt = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mem_req, mem_we, if_ack, dt_ack, grant, busy} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, mem_we, if_ack, dt_ack, grant, busy}); end
        n_cmp++; if ({mem_addr, mem_be, mem_wdata} !== '0) begin n_err++; $display("FAIL reset_payload got=%h exp=0", {mem_addr, mem_be, mem_wdata}); end
        n_cmp++; if ({if_rdata, dt_rdata} !== '0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dt_rdata}); end
        n_cmp++; if (dut.starve_cnt !== 4'd0) begin n_err++; $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt); end
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        int lat; logic gi, gd; exp_t e;
        ws = 0; if_addr = 32'h100; if_req = 1'b1;
        push_exp(1'b0, 1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 32'hE0010009);
        wait_ack(20, lat, gi, gd);
        if_req = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({gi, gd} !== 2'b10) begin n_err++; $display("FAIL fetch_ack got=%b exp=10", {gi, gd}); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
        n_cmp++; if (if_rdata !== e.rdata) begin n_err++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, e.rdata); end
        n_cmp++; if ({grant, busy} !== {e.is_data, 1'b1}) begin n_err++; $display("FAIL fetch_grant_busy got=%b exp=%b", {grant, busy}, {e.is_data, 1'b1}); end
        n_cmp++; if ({last_addr, last_we, last_be, last_wdata} !== {e.addr, e.we, e.be, e.wdata}) begin n_err++; $display("FAIL fetch_payload got=%h exp=%h", {last_addr, last_we, last_be, last_wdata}, {e.addr, e.we, e.be, e.wdata}); end
        n_cmp++; if (last_cycles !== 1) begin n_err++; $display("FAIL fetch_req_cycles got=%0d exp=1", last_cycles); end
        n_cmp++; if (dut.starve_cnt !== 4'(e.cnt)) begin n_err++; $display("FAIL fetch_starve got=%0d exp=%0d", dut.starve_cnt, e.cnt); end
        @(negedge clk);
        n_cmp++; if ({if_ack, mem_req, if_rdata} !== {2'b00, e.rdata}) begin n_err++; $display("FAIL fetch_after got=%h exp=%h", {if_ack, mem_req, if_rdata}, {2'b00, e.rdata}); end
    endtask

    task automatic test_data_write();
        int lat; logic gi, gd; exp_t e;
        ws = 3; dt_addr = 32'h2000; dt_we = 1'b1; dt_be = 4'h3; dt_wdata = 32'hA5A5; dt_req = 1'b1;
        push_exp(1'b1, 1'b0, 32'h2000, 1'b1, 4'h3, 32'hA5A5, exp_dt_rdata);
        wait_ack(30, lat, gi, gd);
        dt_req = 1'b0; dt_we = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({gi, gd} !== 2'b01) begin n_err++; $display("FAIL write_ack got=%b exp=01", {gi, gd}); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL write_latency got=%0d exp=5", lat); end
        n_cmp++; if (last_cycles !== 4 || unstable !== 1'b0) begin n_err++; $display("FAIL write_req_hold got=%0d/%b exp=4/0", last_cycles, unstable); end
        n_cmp++; if ({last_addr, last_we, last_be, last_wdata} !== {e.addr, e.we, e.be, e.wdata}) begin n_err++; $display("FAIL write_payload got=%h exp=%h", {last_addr, last_we, last_be, last_wdata}, {e.addr, e.we, e.be, e.wdata}); end
        n_cmp++; if (dt_rdata !== e.rdata) begin n_err++; $display("FAIL write_rdata_kept got=%h exp=%h", dt_rdata, e.rdata); end
        @(negedge clk);
        n_cmp++; if (dt_ack !== 1'b0) begin n_err++; $display("FAIL write_ack_pulse got=%b exp=0", dt_ack); end
        ws = 0;
    endtask

    task automatic test_contention();
        int lat; logic gi, gd; exp_t e;
        ws = 0; if_addr = 32'h300; dt_addr = 32'h40; dt_we = 1'b0; dt_be = 4'hF; dt_wdata = '0;
        if_req = 1'b1; dt_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m_cnt >= int'(LIMIT)) push_exp(1'b0, 1'b1, 32'h300, 1'b0, 4'hF, 32'h0, mval(32'h300));
            else push_exp(1'b1, 1'b1, 32'h40, 1'b0, 4'hF, 32'h0, mval(32'h40));
        end
        for (int i = 0; i < 8; i++) begin
            wait_ack(20, lat, gi, gd);
            if (i == 7) begin if_req = 1'b0; dt_req = 1'b0; end
            e = sb.pop_front();
            n_cmp++; if ({gi, gd, grant} !== {!e.is_data, e.is_data, e.is_data}) begin n_err++; $display("FAIL contention_grant[%0d] got=%b exp=%b", i, {gi, gd, grant}, {!e.is_data, e.is_data, e.is_data}); end
            n_cmp++; if (lat !== ((i == 0) ? 2 : 3)) begin n_err++; $display("FAIL contention_spacing[%0d] got=%0d exp=%0d", i, lat, (i == 0) ? 2 : 3); end
            n_cmp++; if ((e.is_data ? dt_rdata : if_rdata) !== e.rdata || last_addr !== e.addr) begin n_err++; $display("FAIL contention_data[%0d] got=%h/%h exp=%h/%h", i, e.is_data ? dt_rdata : if_rdata, last_addr, e.rdata, e.addr); end
            n_cmp++; if (dut.starve_cnt !== 4'(e.cnt)) begin n_err++; $display("FAIL contention_starve[%0d] got=%0d exp=%0d", i, dut.starve_cnt, e.cnt); end
            if (e.is_data) exp_dt_rdata = e.rdata;
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int lat; logic gi, gd; exp_t e;
        ws = 0; stall = 1'b1; if_addr = 32'h500; dt_addr = 32'h60; dt_we = 1'b0; dt_be = 4'hF;
        if_req = 1'b1; dt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if ({mem_req, busy} !== 2'b00) begin n_err++; $display("FAIL stall_hold[%0d] got=%b exp=00", i, {mem_req, busy}); end
        end
        stall = 1'b0; ws = 2;
        push_exp(1'b1, 1'b1, 32'h60, 1'b0, 4'hF, 32'h0, mval(32'h60));
        @(negedge clk);
        n_cmp++; if ({mem_req, grant} !== 2'b11) begin n_err++; $display("FAIL stall_release got=%b exp=11", {mem_req, grant}); end
        stall = 1'b1;
        wait_ack(20, lat, gi, gd);
        dt_req = 1'b0;
        e = sb.pop_front();
        exp_dt_rdata = e.rdata;
        n_cmp++; if ({gi, gd, lat} !== {2'b01, 32'd3}) begin n_err++; $display("FAIL stall_busy_ack got=%b/%0d exp=01/3", {gi, gd}, lat); end
        n_cmp++; if (dt_rdata !== e.rdata || dut.starve_cnt !== 4'(e.cnt)) begin n_err++; $display("FAIL stall_result got=%h/%0d exp=%h/%0d", dt_rdata, dut.starve_cnt, e.rdata, e.cnt); end
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_fetch_blocked got=%b exp=0", mem_req); end
        if_req = 1'b0; stall = 1'b0; ws = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        int acks = 0;
        ws = 100; dt_addr = 32'h80; dt_we = 1'b0; dt_req = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstbusy_pending got=%b exp=1", mem_req); end
        n_reset = 1'b0;
        #1;
        n_cmp++; if ({mem_req, busy} !== 2'b00) begin n_err++; $display("FAIL rstbusy_drop got=%b exp=00", {mem_req, busy}); end
        dt_req = 1'b0; m_cnt = 0;
        repeat (2) begin @(negedge clk); acks += int'(if_ack) + int'(dt_ack); end
        n_reset = 1'b1; ws = 0;
        repeat (3) begin @(negedge clk); acks += int'(if_ack) + int'(dt_ack) + int'(mem_req) + int'(busy); end
        n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rstbusy_quiet got=%0d exp=0", acks); end
        n_cmp++; if (dut.starve_cnt !== 4'(m_cnt)) begin n_err++; $display("FAIL rstbusy_starve got=%0d exp=%0d", dut.starve_cnt, m_cnt); end
        exp_dt_rdata = '0;
    endtask

    task automatic test_back_to_back();
        int lat; logic gi, gd; exp_t e; int hs0;
        ws = 0; hs0 = n_hs; dt_addr = 32'h10; dt_we = 1'b0; dt_be = 4'hF; dt_req = 1'b1;
        push_exp(1'b1, 1'b0, 32'h10, 1'b0, 4'hF, 32'h0, mval(32'h10));
        wait_ack(20, lat, gi, gd);
        dt_addr = 32'h14;
        push_exp(1'b1, 1'b0, 32'h14, 1'b0, 4'hF, 32'h0, mval(32'h14));
        e = sb.pop_front();
        n_cmp++; if ({gd, lat, dt_rdata, mem_req} !== {1'b1, 32'd2, e.rdata, 1'b0}) begin n_err++; $display("FAIL b2b_first got=%b/%0d/%h/%b exp=1/2/%h/0", gd, lat, dt_rdata, mem_req, e.rdata); end
        wait_ack(20, lat, gi, gd);
        dt_req = 1'b0;
        e = sb.pop_front();
        n_cmp++; if ({gd, lat} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL b2b_spacing got=%b/%0d exp=1/3", gd, lat); end
        n_cmp++; if (dt_rdata !== e.rdata || last_addr !== e.addr) begin n_err++; $display("FAIL b2b_second got=%h/%h exp=%h/%h", dt_rdata, last_addr, e.rdata, e.addr); end
        repeat (3) @(negedge clk);
        n_cmp++; if (n_hs - hs0 !== 2) begin n_err++; $display("FAIL b2b_mem_count got=%0d exp=2", n_hs - hs0); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_contention();
        test_stall();
        test_reset_busy();
        test_back_to_back();
        n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sh_mem_arbiter.md
# sh_mem_arbiter

Two-requester arbiter that shares one single-ported, variable-latency memory between the CPU instruction-fetch path and the CPU data-access path (MOV.L loads/stores). It sits between the `cpu` core and the unified memory. It serialises transactions through a registered request/ready handshake. Data accesses get fixed priority, with an anti-starvation counter that guarantees fetch progress.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of both requesters and memory
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- STARVE_LIMIT, 3, consecutive data grants lost by a waiting fetch before fetch is forced; range 1..15

Ports:
- clk  in  1  single clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- stall  in  1  1 = no new grant starts; an in-flight transaction completes
- if_req  in  1  fetch request, held with stable if_addr until if_ack
- if_addr  in  ADDR_WIDTH  fetch word address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_WIDTH  fetch read data, valid while if_ack=1, held afterwards
- dt_req  in  1  data request, held with stable payload until dt_ack
- dt_addr  in  ADDR_WIDTH  data address
- dt_we  in  1  1 = write, 0 = read
- dt_be  in  DATA_WIDTH/8  byte enables
- dt_wdata  in  DATA_WIDTH  write data
- dt_ack  out  1  one-cycle completion pulse; also issued for writes
- dt_rdata  out  DATA_WIDTH  read data, valid while dt_ack=1; unchanged on writes
- mem_req  out  1  memory request, held until mem_ready
- mem_addr, mem_we, mem_be, mem_wdata  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  registered payload, stable while mem_req=1
- mem_rdata  in  DATA_WIDTH  sampled when mem_req & mem_ready
- mem_ready  in  1  memory completion, meaningful only while mem_req=1
- grant  out  1  owner of the current transaction: 0 = fetch, 1 = data
- busy  out  1  1 in BUSY or DONE

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - If stall=0 and any req is asserted, pick a winner. Register its payload onto mem_*; mem_req is set to 1 from the next cycle.
  - Go to BUSY.
  - For fetch, the arbiter drives mem_we=0, mem_be=all ones, mem_wdata=0.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless starve_cnt ≥ STARVE_LIMIT, in which case fetch wins.
- starve_cnt (4-bit, internal):
  - Increments, saturating at STARVE_LIMIT, when fetch is requesting and data wins.
  - Clears to 0 when fetch wins.
  - Holds otherwise.
- BUSY:
  - mem_req=1 with a constant payload.
  - On mem_ready=1: capture mem_rdata into the winner's rdata register (reads only), pulse the winner's ack next cycle, drop mem_req next cycle, and go to DONE.
  - With mem_ready=0: stay in BUSY indefinitely. There is no timeout.
- DONE:
  - The winner's ack is 1 for exactly this cycle. req inputs are ignored.
  - Next state is always IDLE.
  - The requester may deassert req, or change its payload, in the cycle after ack.
- stall affects only the IDLE→BUSY decision. It never aborts BUSY.
- Requests that change payload or drop req before ack are protocol violations. Behaviour is undefined and the arbiter does not check for them.

## Timing
- Reset (async, while n_reset=0):
  - State IDLE, starve_cnt=0.
  - mem_req=0, mem_addr=0, mem_we=0, mem_be=0, mem_wdata=0.
  - if_ack=0, dt_ack=0, if_rdata=0, dt_rdata=0, grant=0, busy=0.
  - Reset mid-transaction drops mem_req immediately and no ack is issued.
- Minimum transaction, with mem_ready=1 in the first BUSY cycle:
  - req sampled in cycle 0 (IDLE).
  - mem_req=1 in cycle 1.
  - ack in cycle 2.
  - IDLE again in cycle 3.
  - Latency from req to ack is 2 cycles; peak throughput is 1 transaction per 3 cycles.
- Each extra mem_ready=0 cycle adds exactly 1 cycle of latency.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Simultaneous requests: at most one grant per IDLE cycle. The loser keeps req high and is re-evaluated in the next IDLE cycle.

## Test plan
- Reset, then a single fetch: if_req=1, if_addr=0x100, mem_ready=1 in the first BUSY cycle, mem_rdata=0xE0010009 → mem_req high for 1 cycle with mem_addr=0x100 and mem_be=0xF; if_ack on cycle 2 with if_rdata=0xE0010009.
- Data write with 3 wait states: dt_we=1, dt_addr=0x2000, dt_be=0x3, dt_wdata=0xA5A5 → mem_req high for 4 cycles with stable payload; single dt_ack pulse; dt_rdata unchanged.
- Contention with STARVE_LIMIT=3, both requesting continuously and mem_ready=1 → grant sequence data,data,data,fetch, repeating; starve_cnt returns to 0 after each fetch grant.
- stall=1 with both requesting → mem_req stays 0; grant occurs on the first IDLE cycle after stall falls. stall raised during BUSY → the transaction still completes with an ack.
- Reset asserted in BUSY with mem_ready=0 → mem_req drops immediately; no ack; after release, state is IDLE and starve_cnt=0.
- Back-to-back data reads at 0x10 then 0x14 → two acks 3 cycles apart; the second request is not sampled during the DONE cycle.
